// File: rtl/prog_mod_counter.sv
// Runtime-programmable modulo counter for video timing chains. It supports up/down
// counting, a synchronous load, shadowed min/max bounds, cascade tc and a window compare.
module prog_mod_counter #(
    parameter int WIDTH       = 10,
    parameter int DEFAULT_MIN = 0,
    parameter int DEFAULT_MAX = 799
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_min,
    input  logic [WIDTH-1:0] cfg_max,
    input  logic [WIDTH-1:0] win_start,
    input  logic [WIDTH-1:0] win_end,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             rollover,
    output logic             in_win,
    output logic             cfg_pending,
    output logic             cfg_err
);

    localparam logic [WIDTH-1:0] MIN_RST = WIDTH'(DEFAULT_MIN);
    localparam logic [WIDTH-1:0] MAX_RST = WIDTH'(DEFAULT_MAX);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] act_min, act_max, sh_min, sh_max;
    logic [WIDTH-1:0] count_n, act_min_n, act_max_n, sh_min_n, sh_max_n;
    logic             wrap_cond;
    logic             cfg_ok;

    // A start past the end describes a window that straddles the wrap point.
    function automatic logic win_hit(input logic [WIDTH-1:0] v,
                                     input logic [WIDTH-1:0] s,
                                     input logic [WIDTH-1:0] e);
        if (s <= e) return (v >= s) && (v <= e);
        else        return (v >= s) || (v <= e);
    endfunction

    // Inclusive compares let an out-of-range loaded value wrap on its next step.
    assign wrap_cond = up ? (count >= act_max) : (count <= act_min);
    assign tc        = en & ~load & wrap_cond;
    assign cfg_ok    = (cfg_min <= cfg_max);

    always_comb begin
        count_n   = count;
        act_min_n = act_min;
        act_max_n = act_max;
        sh_min_n  = sh_min;
        sh_max_n  = sh_max;
        if (load) begin
            count_n = load_val;
        end else if (en) begin
            if (wrap_cond) count_n = up ? sh_min : sh_max;
            else           count_n = up ? count + ONE : count - ONE;
        end
        // The wrap adopts the shadow value from before this cycle's write.
        if (tc) begin
            act_min_n = sh_min;
            act_max_n = sh_max;
        end
        if (cfg_we && cfg_ok) begin
            sh_min_n = cfg_min;
            sh_max_n = cfg_max;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= MIN_RST;
            act_min     <= MIN_RST;
            act_max     <= MAX_RST;
            sh_min      <= MIN_RST;
            sh_max      <= MAX_RST;
            rollover    <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_err     <= 1'b0;
            in_win      <= win_hit(MIN_RST, win_start, win_end);
        end else begin
            count       <= count_n;
            act_min     <= act_min_n;
            act_max     <= act_max_n;
            sh_min      <= sh_min_n;
            sh_max      <= sh_max_n;
            rollover    <= tc;
            cfg_pending <= (sh_min_n != act_min_n) || (sh_max_n != act_max_n);
            in_win      <= win_hit(count_n, win_start, win_end);
            if (cfg_we && !cfg_ok) cfg_err <= 1'b1;
        end
    end

endmodule
